// File: rtl/pulse_pair_transmitter.sv
// Purpose: sends a 4-bit word MSB first as one-cycle pulses (a = 1 bit, b = 0 bit), GAP idle cycles after each.
// Latency: first pulse in the cycle after the accepted start; finished pulse 4*(GAP+1) cycles after that.
// Backpressure: none; start is sampled only in IDLE, and any start seen while busy is dropped.
module pulse_pair_transmitter #(
  parameter int GAP = 2  // idle cycles after each pulse, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] data_in,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       finished,
  output logic       two_plus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PULSE  = 2'd1,
    S_GAP    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [7:0] GAP_CNT = 8'(GAP);

  state_t     state, state_n;
  logic [3:0] shreg, shreg_n;
  logic [1:0] bit_idx, bit_idx_n;
  logic [7:0] gap_cnt, gap_cnt_n;
  logic       two_plus_n;
  logic       a_n, b_n, busy_n, finished_n;
  logic [2:0] ones;

  // Registered state and outputs; outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= 4'd0;
      bit_idx  <= 2'd0;
      gap_cnt  <= 8'd0;
      two_plus <= 1'b0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      gap_cnt  <= gap_cnt_n;
      two_plus <= two_plus_n;
      a        <= a_n;
      b        <= b_n;
      busy     <= busy_n;
      finished <= finished_n;
    end
  end

  // Next-state, datapath and next-output decode; the word always presents its current bit at shreg[3].
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    gap_cnt_n  = gap_cnt;
    two_plus_n = two_plus;
    ones       = {2'b00, data_in[0]} + {2'b00, data_in[1]}
               + {2'b00, data_in[2]} + {2'b00, data_in[3]};

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n    = S_PULSE;
          shreg_n    = data_in;
          bit_idx_n  = 2'd3;
          two_plus_n = (ones >= 3'd2);
        end
      end
      S_PULSE: begin
        state_n   = S_GAP;
        gap_cnt_n = GAP_CNT;
      end
      S_GAP: begin
        if (gap_cnt == 8'd1) begin
          gap_cnt_n = 8'd0;
          if (bit_idx == 2'd0) begin
            state_n = S_FINISH;
          end else begin
            state_n   = S_PULSE;
            shreg_n   = {shreg[2:0], 1'b0};
            bit_idx_n = bit_idx - 2'd1;
          end
        end else begin
          gap_cnt_n = gap_cnt - 8'd1;
        end
      end
      S_FINISH: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    a_n        = (state_n == S_PULSE) && shreg_n[3];
    b_n        = (state_n == S_PULSE) && !shreg_n[3];
    busy_n     = (state_n != S_IDLE);
    finished_n = (state_n == S_FINISH);
  end

endmodule

// File: tb/tb_pulse_pair_transmitter.sv
// Purpose: checks pulse timing, bit order, two_plus, finished and reset behaviour on GAP=2 and GAP=1 instances.
// Latency: expected events are queued with their absolute cycle stamps when a start is driven.
// Backpressure: not applicable; the monitors pop whenever a, b or finished is seen.
module tb_pulse_pair_transmitter;

  logic       clk;
  logic       rst;
  logic       start2, start1;
  logic [3:0] data2, data1;
  logic       a2, b2, busy2, fin2, tp2;
  logic       a1, b1, busy1, fin1, tp1;

  typedef struct {
    int         kind;  // 0 = b pulse, 1 = a pulse, 2 = finished
    int         cyc;
    logic       tp;
    logic [3:0] word;
  } ev_t;

  ev_t q2[$];
  ev_t q1[$];
  ev_t ev2, ev1;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  logic [3:0] rx2 = 4'd0, rx1 = 4'd0;
  logic       pf2 = 1'b0, pf1 = 1'b0;

  pulse_pair_transmitter #(.GAP(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .data_in(data2),
    .a(a2), .b(b2), .busy(busy2), .finished(fin2), .two_plus(tp2)
  );

  pulse_pair_transmitter #(.GAP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data1),
    .a(a1), .b(b1), .busy(busy1), .finished(fin1), .two_plus(tp1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue the four bit pulses and the finished pulse of a frame whose start is driven while cyc == base.
  task automatic push_frame(input int inst, input logic [3:0] w, input int base, input int g);
    ev_t  e;
    logic tp;
    tp = ($countones(w) >= 2);
    for (int k = 0; k < 4; k++) begin
      e.kind = w[3-k] ? 1 : 0;
      e.cyc  = base + 1 + k * (g + 1);
      e.tp   = tp;
      e.word = w;
      if (inst == 2) q2.push_back(e); else q1.push_back(e);
    end
    e.kind = 2;
    e.cyc  = base + 1 + 4 * (g + 1);
    e.tp   = tp;
    e.word = w;
    if (inst == 2) q2.push_back(e); else q1.push_back(e);
  endtask

  task automatic compare_ev(input string who, input ev_t e, input logic a, input logic b,
                            input logic fin, input logic busy, input logic tp, input logic [3:0] rx);
    int act_kind;
    act_kind = (a && b) ? 3 : fin ? 2 : a ? 1 : 0;
    check({who, "_kind"}, act_kind, e.kind);
    check({who, "_cycle"}, cyc, e.cyc);
    check({who, "_two_plus"}, int'(tp), int'(e.tp));
    check({who, "_busy"}, int'(busy), 1);
    if (e.kind == 2) check({who, "_loopback_word"}, int'(rx), int'(e.word));
  endtask

  // Monitor for the GAP=2 instance, with a shift-in receiver fed by the a/b pulses.
  always @(negedge clk) begin
    if (pf2) begin
      check("g2_busy_after_finish", int'(busy2), 0);
      pf2 = 1'b0;
    end
    if (a2 || b2 || fin2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL g2_unexpected: got a=%0b b=%0b finished=%0b expected no event (cycle %0d)", a2, b2, fin2, cyc);
      end else begin
        ev2 = q2.pop_front();
        compare_ev("g2", ev2, a2, b2, fin2, busy2, tp2, rx2);
      end
      if (a2 || b2) rx2 = {rx2[2:0], a2};
      if (fin2) pf2 = 1'b1;
    end
  end

  // Monitor for the GAP=1 instance.
  always @(negedge clk) begin
    if (pf1) begin
      check("g1_busy_after_finish", int'(busy1), 0);
      pf1 = 1'b0;
    end
    if (a1 || b1 || fin1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL g1_unexpected: got a=%0b b=%0b finished=%0b expected no event (cycle %0d)", a1, b1, fin1, cyc);
      end else begin
        ev1 = q1.pop_front();
        compare_ev("g1", ev1, a1, b1, fin1, busy1, tp1, rx1);
      end
      if (a1 || b1) rx1 = {rx1[2:0], a1};
      if (fin1) pf1 = 1'b1;
    end
  end

  initial begin
    int base;
    rst    = 1'b1;
    start2 = 1'b0;
    start1 = 1'b0;
    data2  = 4'd0;
    data1  = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_outputs_g2", int'({a2, b2, busy2, fin2, tp2}), 0);
    check("reset_outputs_g1", int'({a1, b1, busy1, fin1, tp1}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1010 with GAP=2: a at 1,7; b at 4,10; finished at 13.
    base = cyc; start2 = 1'b1; data2 = 4'b1010;
    push_frame(2, 4'b1010, base, 2);
    @(negedge clk); start2 = 1'b0;
    while (cyc < base + 16) @(negedge clk);

    // 0001 with GAP=2; data changes to 1111 mid-frame and a stray start at cycle 5 must be ignored.
    base = cyc; start2 = 1'b1; data2 = 4'b0001;
    push_frame(2, 4'b0001, base, 2);
    @(negedge clk); start2 = 1'b0;
    while (cyc < base + 2) @(negedge clk);
    data2 = 4'b1111;
    while (cyc < base + 4) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    while (cyc < base + 20) @(negedge clk);

    // GAP=1 with start held high: two back-to-back frames, second first pulse at cycle 11.
    base = cyc; start1 = 1'b1; data1 = 4'b1111;
    push_frame(1, 4'b1111, base, 1);
    push_frame(1, 4'b1111, base + 10, 1);
    while (cyc < base + 11) @(negedge clk);
    start1 = 1'b0;
    while (cyc < base + 25) @(negedge clk);

    // Loopback of all 16 words on GAP=2, with data_in scrambled right after capture.
    for (int v = 0; v < 16; v++) begin
      base = cyc; start2 = 1'b1; data2 = 4'(v);
      push_frame(2, 4'(v), base, 2);
      @(negedge clk); start2 = 1'b0; data2 = ~4'(v);
      while (cyc < base + 14) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Asynchronous reset at cycle 6 of a frame, then start held through reset and accepted on release.
    base = cyc; start2 = 1'b1; data2 = 4'b1011;
    push_frame(2, 4'b1011, base, 2);
    @(negedge clk); start2 = 1'b0;
    while (cyc < base + 6) @(negedge clk);
    check("pre_reset_busy", int'(busy2), 1);
    #2 rst = 1'b1;
    q2.delete();
    #1;
    check("async_reset_a_b_busy_tp", int'({a2, b2, busy2, tp2}), 0);
    start2 = 1'b1; data2 = 4'b0110;
    repeat (3) @(negedge clk);
    check("held_in_reset_busy", int'(busy2), 0);
    rst  = 1'b0;
    base = cyc;
    push_frame(2, 4'b0110, base, 2);
    @(negedge clk); start2 = 1'b0;
    while (cyc < base + 20) @(negedge clk);

    check("g2_queue_drained", q2.size(), 0);
    check("g1_queue_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_pair_transmitter.md
PULSE_PAIR_TRANSMITTER -- requirements
Module: pulse_pair_transmitter

Interface
REQ-001 Parameter GAP, default 2: idle cycles (a=b=0) after each bit pulse; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to send data_in; sampled only in IDLE.
REQ-005 data_in  input  4  word to transmit; captured on the accepted start edge.
REQ-006 a  output  1  one-cycle pulse marking a transmitted 1 bit.
REQ-007 b  output  1  one-cycle pulse marking a transmitted 0 bit.
REQ-008 busy  output  1  high from the cycle after an accepted start through the FINISH cycle.
REQ-009 finished  output  1  one-cycle pulse after the last bit's gap completes.
REQ-010 two_plus  output  1  latched flag: popcount(captured word) >= 2; held until the next accepted start.

Function
REQ-011 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-012 FSM states SHALL be IDLE, PULSE, GAP, FINISH; reset state IDLE.
REQ-013 IDLE: on posedge with start=1, the block SHALL capture data_in into shift register, load bit index 3, latch two_plus, and go to PULSE; otherwise it stays in IDLE.
REQ-014 PULSE (1 cycle): the block SHALL drive a=1,b=0 if the current bit is 1, else a=0,b=1; next state GAP with gap counter loaded to GAP.
REQ-015 GAP: a=b=0; the counter SHALL decrement each cycle; after exactly GAP cycles the block goes to PULSE for the next bit, or to FINISH if the bit index was 0.
REQ-016 Bit order SHALL be MSB first: data_in[3], [2], [1], [0].
REQ-017 FINISH (1 cycle): finished=1, a=b=0, busy=1; next state IDLE.
REQ-018 a and b SHALL never be high in the same cycle, and each pulse SHALL be followed by at least one low cycle (guaranteed by GAP>=1).
REQ-019 Timing: with start accepted at edge 0, bit k (k=0 first) pulses in cycle 1+k*(GAP+1); finished in cycle 1+4*(GAP+1); the block accepts a new start in the cycle after finished.
REQ-020 start while busy=1 SHALL be ignored and SHALL NOT alter the captured word, two_plus, or timing.
REQ-021 start held high continuously SHALL produce back-to-back frames with exactly one IDLE cycle between finished and the next first pulse.
REQ-022 Changes on data_in after capture SHALL NOT affect the frame in progress.
REQ-023 two_plus SHALL be computed with a 3-bit sum of the four captured bits.

Reset
REQ-024 rst=1 SHALL immediately (asynchronously) force state IDLE, a=0, b=0, busy=0, finished=0, two_plus=0, counters and shift register 0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no further pulses; after release the block waits in IDLE for a new start.
REQ-026 A start coincident with the rst-release edge SHALL be accepted only if rst is low at that posedge.

Verification
REQ-027 GAP=2, start with data_in=4'b1010 -> a pulses cycles 1,7; b pulses cycles 4,10; finished cycle 13; two_plus=1; busy high cycles 1..13.
REQ-028 GAP=2, data_in=4'b0001 -> b at 1,4,7; a at 10; two_plus=0; data_in changed to 4'b1111 at cycle 3 has no effect.
REQ-029 GAP=1, start held high, data_in=4'b1111 -> a at 1,3,5,7, finished 9, IDLE 10, next frame pulse at 11; a/b never both high.
REQ-030 start pulsed again at cycle 5 of a frame -> ignored; frame completes unchanged; no second frame.
REQ-031 rst asserted asynchronously at cycle 6 (GAP=2) -> a,b,busy,two_plus drop to 0 without waiting for an edge; no pulses until new start after release.
REQ-032 Loopback: drive a/b into the team's edge-detecting receiver -> its 4-bit register equals captured word and its two-or-more flag equals two_plus for all 16 values.
